// File: rtl/sig_change_monitor.sv
// Change-capture stage: records a timestamped snapshot on the first enabled cycle and
// a record on every change of sample_in, buffered in a FWFT FIFO. Optional macro SIG_CHG_MON_DROP_CNT_EN adds drop_count.
module sig_change_monitor #(
    parameter int W     = 3,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [W-1:0]    sample_in,
    output logic            rec_valid,
    input  logic            rec_ready,
    output logic [TS_W-1:0] rec_ts,
    output logic [W-1:0]    rec_data,
    output logic            rec_first,
    output logic            fifo_full,
    output logic            drop_pulse
`ifdef SIG_CHG_MON_DROP_CNT_EN
    ,
    output logic [7:0]      drop_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = TS_W + W + 1;
    localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);

    logic [TS_W-1:0] ts_q;
    logic [W-1:0]    prev_q;
    logic            arm_q;
    logic [AW:0]     wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [RW-1:0]   mem_q [DEPTH];
    logic [RW-1:0]   head_q, head_d, push_rec;
    logic            drop_pulse_q;
    logic            push, pop, fifo_empty, full_now, accept, drop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign full_now   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = enable && (arm_q || (sample_in != prev_q));
    assign pop        = !fifo_empty && rec_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO is only lost without one.
    assign accept     = push && (!full_now || pop);
    assign drop       = push && full_now && !pop;
    assign push_rec   = {ts_q, sample_in, arm_q};

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, accept};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        head_d   = head_q;
        // The head register holds its last value when the FIFO drains; when the new head
        // is the entry being written this edge it comes straight from push_rec.
        if (wr_ptr_d != rd_ptr_d) begin
            if (rd_ptr_d == wr_ptr_q) begin
                head_d = push_rec;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q         <= '0;
            prev_q       <= '0;
            arm_q        <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_q       <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            ts_q         <= ts_q + TS_ONE;
            if (enable) begin
                prev_q <= sample_in;
            end
            arm_q        <= !enable;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            head_q       <= head_d;
            drop_pulse_q <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
        end
    end

`ifdef SIG_CHG_MON_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    assign rec_valid  = !fifo_empty;
    assign fifo_full  = full_now;
    assign rec_ts     = head_q[RW-1 -: TS_W];
    assign rec_data   = head_q[W:1];
    assign rec_first  = head_q[0];
    assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_sig_change_monitor.sv
// Randomized scoreboard bench for sig_change_monitor; a narrow timestamp exercises wrap-around.
module tb_sig_change_monitor;
    localparam int W     = 3;
    localparam int TS_W  = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [W-1:0]    data;
        logic            first;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [W-1:0]    sample_in;
    logic            rec_valid;
    logic            rec_ready;
    logic [TS_W-1:0] rec_ts;
    logic [W-1:0]    rec_data;
    logic            rec_first;
    logic            fifo_full;
    logic            drop_pulse;
`ifdef SIG_CHG_MON_DROP_CNT_EN
    logic [7:0]      drop_count;
    int              m_dropcnt;
`endif

    sig_change_monitor #(.W(W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sample_in  (sample_in),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_ts     (rec_ts),
        .rec_data   (rec_data),
        .rec_first  (rec_first),
        .fifo_full  (fifo_full),
        .drop_pulse (drop_pulse)
`ifdef SIG_CHG_MON_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t exp_q[$];
    rec_t last_rec = '0;

    // Reference model state: elapsed cycles since reset, last enabled sample, arm status.
    logic [TS_W-1:0] m_ts;
    logic [W-1:0]    m_prev;
    logic            m_armed;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ts     = '0;
        m_prev   = '0;
        m_armed  = 1'b1;
        exp_q.delete();
        last_rec = '0;
`ifdef SIG_CHG_MON_DROP_CNT_EN
        m_dropcnt = 0;
`endif
    endtask

    task automatic check_reset_outputs();
        chk("rst_rec_valid", 32'(rec_valid), 32'(0));
        chk("rst_rec_ts", 32'(rec_ts), 32'(0));
        chk("rst_rec_data", 32'(rec_data), 32'(0));
        chk("rst_rec_first", 32'(rec_first), 32'(0));
        chk("rst_fifo_full", 32'(fifo_full), 32'(0));
        chk("rst_drop_pulse", 32'(drop_pulse), 32'(0));
`ifdef SIG_CHG_MON_DROP_CNT_EN
        chk("rst_drop_count", 32'(drop_count), 32'(0));
`endif
    endtask

    // Monitor: compares the presented head against the scoreboard and retires it on a handshake.
    always @(negedge clk) begin
        chk("rec_valid", 32'(rec_valid), 32'(exp_q.size() != 0));
        chk("fifo_full", 32'(fifo_full), 32'(exp_q.size() == DEPTH));
        if (rec_valid && exp_q.size() != 0) begin
            chk("rec_ts", 32'(rec_ts), 32'(exp_q[0].ts));
            chk("rec_data", 32'(rec_data), 32'(exp_q[0].data));
            chk("rec_first", 32'(rec_first), 32'(exp_q[0].first));
            $display("rec ts=%0d data=%b first=%0d ready=%0d", rec_ts, rec_data, rec_first, rec_ready);
            if (rec_ready) begin
                last_rec = exp_q.pop_front();
            end
        end else if (!rec_valid) begin
            chk("hold_data", 32'({rec_ts, rec_data, rec_first}), 32'(last_rec));
        end
    end

    initial begin
        logic want;
        logic exp_drop;
        rec_t r;
        int   mode;

        rst_n     = 1'b0;
        enable    = 1'b0;
        sample_in = '0;
        rec_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        #3 rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            mode = (cyc / 50) % 4;
            if (cyc < 8) begin
                enable    = 1'b1;
                sample_in = 3'b001;
                rec_ready = 1'b0;
            end else begin
                enable    = (mode == 3) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) != 0);
                rec_ready = (mode == 0) ? 1'b1 :
                            (mode == 1) ? 1'b0 :
                            (mode == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
                if (mode == 1) begin
                    sample_in = sample_in ^ 3'b001;
                end else if ($urandom_range(0, 1) == 1) begin
                    sample_in = W'($urandom);
                end
            end

            if (cyc % 400 == 399) begin
                #1 rst_n = 1'b0;
                #1;
                check_reset_outputs();
                $display("async reset pulse with %0d records pending", exp_q.size());
                model_reset();
                rst_n = 1'b1;
            end

            @(posedge clk);
            #1;
            // Reference model for the edge just taken.
            want = 1'b0;
            r    = '{ts: m_ts, data: sample_in, first: m_armed};
            if (enable) begin
                want    = m_armed || (sample_in != m_prev);
                m_prev  = sample_in;
                m_armed = 1'b0;
            end else begin
                m_armed = 1'b1;
            end
            exp_drop = want && (exp_q.size() == DEPTH);
            if (want && !exp_drop) begin
                exp_q.push_back(r);
            end
`ifdef SIG_CHG_MON_DROP_CNT_EN
            if (exp_drop && m_dropcnt < 255) m_dropcnt++;
            chk("drop_count", 32'(drop_count), 32'(m_dropcnt));
`endif
            chk("drop_pulse", 32'(drop_pulse), 32'(exp_drop));
            m_ts = m_ts + 1'b1;
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sig_change_monitor.md
# sig_change_monitor

Synthesizable change-capture stage that sits directly downstream of the stimulus registers `a`, `b`, `c`. It is the hardware equivalent of `$monitor` for those registers:
- Samples the packed vector every clock.
- Emits a timestamped snapshot record on the first enabled cycle, then one record whenever any bit changes.
- Buffers records in a small FIFO toward a valid/ready log consumer.

## Interface
- `W`, 3 — sampled vector width; bit order is {a, b, c}, MSB first
- `TS_W`, 16 — timestamp width, in clock cycles
- `DEPTH`, 4 — FIFO entries; must be a power of 2 and at least 2

- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `enable` in 1 — capture enable
- `sample_in` in W — vector under observation
- `rec_valid` out 1 — FIFO head holds a record
- `rec_ready` in 1 — consumer accepts the head record
- `rec_ts` out TS_W — timestamp of the head record
- `rec_data` out W — sampled value of the head record
- `rec_first` out 1 — head record is a snapshot, not a change
- `fifo_full` out 1 — FIFO occupancy equals DEPTH
- `drop_pulse` out 1 — one-cycle pulse when a record was discarded
- `drop_count` out 8 — saturating drop counter; present only with the macro (see Configuration)

## Operation
- **Timestamp counter `ts`**
  - Free-running and increments every cycle regardless of `enable`.
  - Wraps from 2^TS_W−1 to 0 with no flag.
- **Previous-value register `prev`**
  - Loads `sample_in` on every cycle that `enable`=1.
  - Holds its value while `enable`=0.
- **Arm flag**
  - Set by reset and on any cycle where `enable`=0.
  - Cleared on the first cycle where `enable`=1.
- **Record generation** (evaluated only on edges where `enable`=1)
  - If arm=1: push a snapshot {ts, sample_in, first=1}.
  - Else if `sample_in` != `prev`: push a change record {ts, sample_in, first=0}.
  - Else: no push.
- **Recorded timestamp**
  - The record carries the `ts` value present before that edge's increment.
  - Example: the first enabled edge after reset records ts=0.
- **FIFO**
  - First-word-fall-through: `rec_ts`, `rec_data` and `rec_first` always show the head entry.
  - When the FIFO is empty, `rec_valid`=0 and the data outputs hold their last value; they are 0 after reset.
  - Pop occurs on an edge with `rec_valid`=1 and `rec_ready`=1.
  - Pointers are log2(DEPTH) bits plus one wrap bit.
- **Full FIFO**
  - A push arriving when the FIFO is full and there is no simultaneous pop is discarded.
  - `drop_pulse`=1 for exactly the following cycle.
  - `prev` still updates, so the next change is compared against the true current value.
- **Simultaneous push and pop**
  - When full: both are accepted and occupancy is unchanged.
  - When empty: the push is written and `rec_valid` rises the next cycle. There is no same-cycle bypass.
- **Consumer protocol**
  - The consumer may hold `rec_ready` high permanently.
  - `rec_valid` with its data remains stable until the head is popped.
- **Reset**
  - Asynchronous assertion at any time immediately clears the FIFO, `ts`, `prev`, `drop_pulse` and `drop_count`, and sets arm.
  - All pending records are lost.

## Timing
- Reset values:
  - `rec_valid`=0, `rec_ts`=0, `rec_data`=0, `rec_first`=0.
  - `fifo_full`=0, `drop_pulse`=0, `drop_count`=0.
- Latency: a change sampled at edge N produces `rec_valid`=1 after edge N if the FIFO was empty.
- Throughput: one push and one pop per cycle.
- `fifo_full` is registered and reflects occupancy after the current edge.
- `drop_pulse` is registered and high only in the cycle after the dropping edge.
- Deassertion of `rst_n` is synchronized externally. The first edge with `rst_n`=1 may already capture.

## Configuration
- Macro: `SIG_CHG_MON_DROP_CNT_EN`.
- **Defined**
  - Port `drop_count[7:0]` exists.
  - It increments on each discarded record and saturates at 255.
  - It is cleared only by reset.
- **Undefined**
  - Port and counter are absent.
  - Drops are signalled only via `drop_pulse`.
  - All other behaviour is identical.

## Test plan
- **Snapshot after reset:** reset, then `enable`=1 with `sample_in`=3'b001 held constant, `rec_ready`=0.
  - Exactly one record {ts=0, data=001, first=1}.
  - `rec_valid` stays high and no further records appear.
- **Change stream:** `sample_in` changes 001→101 at ts=2, →001 at ts=5, →011 at ts=6; `rec_ready`=1.
  - Records appear in order: ts=0/001/first, ts=2/101, ts=5/001, ts=6/011.
- **Overflow:** DEPTH=4, `rec_ready`=0, toggle bit 0 every cycle for 8 enabled edges.
  - Four records are stored (snapshot plus three changes).
  - `fifo_full`=1.
  - Four `drop_pulse` cycles occur.
  - With the macro, `drop_count`=4.
- **Push/pop while full:** with the FIFO full, assert `rec_ready`=1 during a change.
  - Occupancy stays 4.
  - No drop.
  - The new record appears last in order.
- **Enable gap and wrap:** TS_W=4, `enable` low at ts=7 and high again at ts=12 with an unchanged sample.
  - A new snapshot with first=1 and ts=12 is pushed.
  - Later records wrap from ts=15 to 0 correctly.
- **Mid-operation reset:** pulse `rst_n` low asynchronously between edges while 3 records are pending.
  - Outputs go to reset values immediately.
  - The next enabled edge yields a snapshot with ts=0.
